// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the LED dot-matrix row scanner:
//   ROWS_DEF / COLS_DEF : default matrix geometry
//   state_e             : scanner FSM state encoding (IDLE, BLANK, DRIVE)
//   addr_width()        : width of a row address for a given row count
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // A single-row matrix still needs a one-bit address to keep ports legal.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_scanner_if.sv
// -----------------------------------------------------------------------------
// matrix_scanner_if
// Host-side frame-store bus of the row scanner.
//   WE        : write strobe into the back buffer
//   WADDR     : row address of WDATA
//   WDATA     : row pattern, bit i = column i, 1 = LED on
//   SWAP      : one-cycle request to exchange front/back buffers
//   SWAP_DONE : one-cycle pulse when the swap is applied (scanner -> host)
// master = host, slave = scanner.
// -----------------------------------------------------------------------------
interface matrix_scanner_if #(
  parameter int ROWS = matrix_pkg::ROWS_DEF,
  parameter int COLS = matrix_pkg::COLS_DEF
);

  localparam int AW = matrix_pkg::addr_width(ROWS);

  logic          WE;
  logic [AW-1:0] WADDR;
  logic [COLS-1:0] WDATA;
  logic          SWAP;
  logic          SWAP_DONE;

  modport master (output WE, WADDR, WDATA, SWAP, input SWAP_DONE);
  modport slave  (input WE, WADDR, WDATA, SWAP, output SWAP_DONE);

endinterface

// File: rtl/matrix_framebuf.sv
// -----------------------------------------------------------------------------
// matrix_framebuf
// Double-buffered frame store. Writes always go to the back buffer; a swap
// request is remembered (sticky) and applied only when the scanner signals
// the frame wrap point, so a displayed frame is never torn.
//   clk, rst      : clock, synchronous active-high reset (clears both stores)
//   we_i/waddr_i/wdata_i : back-buffer write port
//   swap_req_i    : swap request strobe
//   swap_point_i  : scanner is at the row ROWS-1 -> 0 wrap this cycle
//   rd_idx_i      : row to read from the front buffer
//   rd_data_o     : combinational front[rd_idx_i]
//   swap_fire_o   : swap is applied this cycle
// -----------------------------------------------------------------------------
module matrix_framebuf
  import matrix_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we_i,
  input  logic [addr_width(ROWS)-1:0] waddr_i,
  input  logic [COLS-1:0]             wdata_i,
  input  logic                        swap_req_i,
  input  logic                        swap_point_i,
  input  logic [addr_width(ROWS)-1:0] rd_idx_i,
  output logic [COLS-1:0]             rd_data_o,
  output logic                        swap_fire_o
);

  logic [COLS-1:0] buf0_q [ROWS];
  logic [COLS-1:0] buf0_d [ROWS];
  logic [COLS-1:0] buf1_q [ROWS];
  logic [COLS-1:0] buf1_d [ROWS];
  logic            front_sel_q, front_sel_d;
  logic            swap_pend_q, swap_pend_d;

  // Next-state of the stores, front select and pending-swap flag.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    // A request arriving in the wrap cycle itself joins that swap.
    swap_fire_o = swap_point_i & (swap_pend_q | swap_req_i);
    // The write targets the pre-swap back buffer, so a write in the swap
    // cycle lands in what becomes the front.
    if (we_i) begin
      if (front_sel_q) begin
        buf0_d[waddr_i] = wdata_i;
      end else begin
        buf1_d[waddr_i] = wdata_i;
      end
    end else begin
      buf0_d = buf0_q;
    end
    if (swap_fire_o) begin
      front_sel_d = ~front_sel_q;
      swap_pend_d = 1'b0;
    end else begin
      front_sel_d = front_sel_q;
      swap_pend_d = swap_pend_q | swap_req_i;
    end
  end

  // Front-buffer read port.
  always_comb begin
    if (front_sel_q) begin
      rd_data_o = buf1_q[rd_idx_i];
    end else begin
      rd_data_o = buf0_q[rd_idx_i];
    end
  end

  // Store and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        buf0_q[i] <= '0;
        buf1_q[i] <= '0;
      end
      front_sel_q <= 1'b0;
      swap_pend_q <= 1'b0;
    end else begin
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      front_sel_q <= front_sel_d;
      swap_pend_q <= swap_pend_d;
    end
  end

endmodule

// File: rtl/matrix_scanner.sv
// -----------------------------------------------------------------------------
// matrix_scanner
// Row-scan driver for an LED dot matrix. Every toggle of SCAN_CLK is one scan
// tick: the current row is switched off, BLANK_CYCLES cycles of blanking
// follow, then the next row is driven from the front frame buffer.
//   CLK, RST     : system clock, synchronous active-high reset
//   SCAN_CLK     : divider output, already in the CLK domain
//   host         : frame-store bus (WE/WADDR/WDATA/SWAP in, SWAP_DONE out)
//   ROW          : one-hot row select, polarity set by ROW_ACTIVE_LOW
//   COL          : column data of the driven row, active high
//   FRAME_START  : pulse in the first DRIVE cycle of row 0
//   TICK_OVERRUN : pulse when a tick lands during blanking and is dropped
// -----------------------------------------------------------------------------
module matrix_scanner
  import matrix_pkg::*;
#(
  parameter int ROWS           = ROWS_DEF,
  parameter int COLS           = COLS_DEF,
  parameter int BLANK_CYCLES   = 4,
  parameter bit ROW_ACTIVE_LOW = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SCAN_CLK,
  matrix_scanner_if.slave  host,
  output logic [ROWS-1:0]  ROW,
  output logic [COLS-1:0]  COL,
  output logic             FRAME_START,
  output logic             TICK_OVERRUN
);

  localparam int AW = addr_width(ROWS);
  localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);
  localparam logic [ROWS-1:0] ROW_OFF = {ROWS{ROW_ACTIVE_LOW}};

  state_e          state_q, state_d;
  logic [AW-1:0]   row_idx_q, row_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ROWS-1:0] row_q, row_d;
  logic [COLS-1:0] col_q, col_d;
  logic            frame_start_q, frame_start_d;
  logic            swap_done_q, swap_done_d;
  logic            overrun_q, overrun_d;
  logic            scan_q;
  logic            tick_s;
  logic            swap_point_s;
  logic            swap_fire_s;
  logic [COLS-1:0] front_row_s;

  function automatic logic [ROWS-1:0] row_sel(input logic [AW-1:0] idx);
    logic [ROWS-1:0] oh;
    oh = ROWS'(1'b1) << idx;
    return ROW_ACTIVE_LOW ? ~oh : oh;
  endfunction

  assign tick_s         = SCAN_CLK ^ scan_q;
  assign ROW            = row_q;
  assign COL            = col_q;
  assign FRAME_START    = frame_start_q;
  assign TICK_OVERRUN   = overrun_q;
  assign host.SWAP_DONE = swap_done_q;

  matrix_framebuf #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_framebuf (
    .clk          (CLK),
    .rst          (RST),
    .we_i         (host.WE),
    .waddr_i      (host.WADDR),
    .wdata_i      (host.WDATA),
    .swap_req_i   (host.SWAP),
    .swap_point_i (swap_point_s),
    .rd_idx_i     (row_idx_d),
    .rd_data_o    (front_row_s),
    .swap_fire_o  (swap_fire_s)
  );

  // Scan FSM next state plus the values the output registers will load.
  always_comb begin
    state_d       = state_q;
    row_idx_d     = row_idx_q;
    cnt_d         = cnt_q;
    frame_start_d = 1'b0;
    overrun_d     = 1'b0;
    swap_point_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BLANK: begin
        // A tick during blanking is dropped; the blank count is not restarted.
        overrun_d = tick_s;
        if (cnt_q == CNT_LAST) begin
          state_d       = ST_DRIVE;
          cnt_d         = '0;
          frame_start_d = (row_idx_q == '0);
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      ST_DRIVE: begin
        if (tick_s) begin
          state_d      = ST_BLANK;
          cnt_d        = '0;
          // ROWS is a power of two, so the increment wraps on its own.
          row_idx_d    = row_idx_q + AW'(1'b1);
          swap_point_s = (row_idx_q == ROW_LAST);
        end else begin
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        row_idx_d = '0;
        cnt_d     = '0;
      end
    endcase
    swap_done_d = swap_fire_s;
    if (state_d == ST_DRIVE) begin
      row_d = row_sel(row_idx_d);
      col_d = front_row_s;
    end else begin
      row_d = ROW_OFF;
      col_d = '0;
    end
  end

  // Scan-clock sampler; follows SCAN_CLK through reset so release never ticks.
  always_ff @(posedge CLK) begin
    scan_q <= SCAN_CLK;
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      row_idx_q     <= '0;
      cnt_q         <= '0;
      row_q         <= ROW_OFF;
      col_q         <= '0;
      frame_start_q <= 1'b0;
      swap_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_idx_q     <= row_idx_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      col_q         <= col_d;
      frame_start_q <= frame_start_d;
      swap_done_q   <= swap_done_d;
      overrun_q     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_matrix_scanner
// Directed sequence with randomized data and timing. The reference keeps the
// two frame stores, the front index and a pending-swap flag as plain arrays,
// and derives each expected row from the "next row, blank, drive" rules.
// -----------------------------------------------------------------------------
module tb_matrix_scanner;

  localparam int BC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_clk;
  logic [7:0] row;
  logic [7:0] col;
  logic       frame_start;
  logic       tick_overrun;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: mb[m_sel] is the displayed frame, the other is back.
  logic [7:0] mb [2][8];
  int         m_sel;
  int         m_row;   // -1 while idle
  bit         m_pend;

  matrix_scanner_if #(.ROWS(8), .COLS(8)) host ();

  matrix_scanner #(
    .ROWS(8), .COLS(8), .BLANK_CYCLES(BC), .ROW_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .SCAN_CLK     (scan_clk),
    .host         (host),
    .ROW          (row),
    .COL          (col),
    .FRAME_START  (frame_start),
    .TICK_OVERRUN (tick_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_row(input int r);
    return 8'hFF ^ (8'h01 << r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++) mb[b][i] = 8'h00;
    m_sel  = 0;
    m_row  = -1;
    m_pend = 1'b0;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_row"}, row, 8'hFF);
    chk({tag, "_col"}, col, 8'h00);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_sd"}, host.SWAP_DONE, 1'b0);
    chk({tag, "_ovr"}, tick_overrun, 1'b0);
  endtask

  // Tick to the next row (optionally with WE/SWAP in the tick cycle and a
  // dropped tick at blank step ovr_k), then hold the row for 'hold' cycles.
  task automatic scan_row(input bit sw, input bit we, input int wa,
                          input logic [7:0] wd, input int ovr_k, input int hold);
    bit wrap;
    bit exp_sd;
    int nr;
    wrap = (m_row == 7);
    nr   = (m_row < 0) ? 0 : (m_row + 1) % 8;
    scan_clk   = ~scan_clk;
    host.SWAP  = sw;
    host.WE    = we;
    host.WADDR = 3'(wa);
    host.WDATA = wd;
    if (we) mb[1 - m_sel][wa] = wd;
    if (sw) m_pend = 1'b1;
    exp_sd = wrap && m_pend;
    if (exp_sd) begin
      m_sel  = 1 - m_sel;
      m_pend = 1'b0;
    end
    step();
    host.SWAP = 1'b0;
    host.WE   = 1'b0;
    chk("tick_row_off", row, 8'hFF);
    chk("tick_col_off", col, 8'h00);
    chk("swap_done", host.SWAP_DONE, exp_sd);
    chk("tick_ovr", tick_overrun, 1'b0);
    m_row = nr;
    for (int k = 1; k <= BC; k++) begin
      if (k == ovr_k) scan_clk = ~scan_clk;
      step();
      if (k < BC) begin
        chk("blank_row", row, 8'hFF);
        chk("blank_ovr", tick_overrun, (k == ovr_k) ? 1'b1 : 1'b0);
        chk("blank_sd", host.SWAP_DONE, 1'b0);
      end else begin
        chk("drive_row", row, exp_row(nr));
        chk("drive_col", col, mb[m_sel][nr]);
        chk("frame_start", frame_start, (nr == 0) ? 1'b1 : 1'b0);
        chk("drive_ovr", tick_overrun, 1'b0);
      end
    end
    // Hold the row; random back-buffer writes and swap requests must not
    // disturb what is shown.
    for (int h = 0; h < hold; h++) begin
      if ($urandom_range(0, 1) == 1) begin
        host.WE    = 1'b1;
        host.WADDR = 3'($urandom_range(0, 7));
        host.WDATA = 8'($urandom);
        mb[1 - m_sel][host.WADDR] = host.WDATA;
      end
      if ($urandom_range(0, 3) == 0) begin
        host.SWAP = 1'b1;
        m_pend    = 1'b1;
      end
      step();
      host.WE   = 1'b0;
      host.SWAP = 1'b0;
      chk("hold_row", row, exp_row(nr));
      chk("hold_col", col, mb[m_sel][nr]);
      chk("hold_fs", frame_start, 1'b0);
      chk("hold_sd", host.SWAP_DONE, 1'b0);
    end
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    host.WE    = 1'b1;
    host.WADDR = 3'(a);
    host.WDATA = d;
    mb[1 - m_sel][a] = d;
    step();
    host.WE = 1'b0;
  endtask

  initial begin
    bit sw;
    bit we;
    int ok;
    rst        = 1'b1;
    scan_clk   = 1'b1;
    host.WE    = 1'b0;
    host.WADDR = 3'd0;
    host.WDATA = 8'h00;
    host.SWAP  = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held three cycles, then idle with no tick.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_off("reset");
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_off("idle");
    end

    // First row from idle, cleared buffers, then the rest of the frame.
    scan_row(1'b0, 1'b0, 0, 8'h00, 0, 2);
    for (int r = 1; r < 8; r++) scan_row(1'b0, 1'b0, 0, 8'h00, 0, $urandom_range(0, 2));

    // Walking-one frame through a swap at the wrap.
    for (int i = 0; i < 8; i++) host_write(i, 8'h01 << i);
    host.SWAP = 1'b1;
    m_pend    = 1'b1;
    step();
    host.SWAP = 1'b0;
    for (int r = 0; r < 8; r++) begin
      scan_row(1'b0, 1'b0, 0, 8'h00, 0, 1);
      chk("walk_col", col, 8'h01 << r);
    end

    // Write plus swap in the wrap cycle: the write is shown on row 0.
    scan_row(1'b1, 1'b1, 0, 8'hAA, 0, 1);
    chk("aa_col", col, 8'hAA);

    // Dropped tick at blank step 2.
    scan_row(1'b0, 1'b0, 0, 8'h00, 2, 1);

    // Randomized frames: data, swap timing, overruns and hold lengths.
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 8; r++) begin
        sw = ($urandom_range(0, 3) == 0);
        we = ($urandom_range(0, 1) == 1);
        ok = ($urandom_range(0, 2) == 0) ? $urandom_range(1, BC - 1) : 0;
        scan_row(sw, we, $urandom_range(0, 7), 8'($urandom), ok, $urandom_range(0, 3));
      end
    end

    // Mid-frame reset while driving row 5 with a swap pending.
    while (m_row != 5) scan_row(1'b0, 1'b0, 0, 8'h00, 0, 0);
    host_write(3, 8'h5C);
    host.SWAP = 1'b1;
    m_pend    = 1'b1;
    step();
    host.SWAP = 1'b0;
    rst = 1'b1;
    step();
    chk_off("mid_reset");
    step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk_off("post_reset_idle");
    end
    for (int r = 0; r < 9; r++) scan_row(1'b0, 1'b0, 0, 8'h00, 0, 1);
    chk("post_reset_row", row, 8'hFE);
    chk("post_reset_col", col, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
